i2c_master_prog: RTL
====================

Name: i2c_master_prog

Overview:
- Single-master I2C controller that drives the programming bus of the processor's I2C slave port.
- Issues one single-byte transaction per command: write or read.
- Frame: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Used by the test harness and a future on-chip loader to write and read back program bytes over the shared SDA/SCL lines.

Parameters:
- CLK_DIV, default 4: clk cycles per quarter SCL period (Q). SCL period = 4*CLK_DIV clk cycles. Legal range 1..255.

Ports:
- clk  input  1  system clock
- i2c_rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; sampled only when busy=0
- rw  input  1  0=write, 1=read; latched on start
- addr  input  7  target address; latched on start
- wdata  input  8  write byte; latched on start
- sda_in  input  1  SDA line level
- scl_in  input  1  SCL line level (used only with stretching)
- scl_oe  output  1  1 = pull SCL low; 0 = release
- sda_oe  output  1  1 = pull SDA low; 0 = release
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at end of STOP
- ack_err  output  1  NACK seen on the last transaction; held until next start
- rdata  output  8  byte received on read; valid when done pulses

Behaviour:
- Reset (async, active-high): scl_oe=0, sda_oe=0, busy=0, done=0, ack_err=0, rdata=0, state=IDLE, counters cleared. Reset mid-transfer releases both lines immediately; no STOP is generated.
- Quarter tick: a down-counter reloads to CLK_DIV-1 and ticks each Q. All line changes occur on tick boundaries.
- IDLE: lines released. On start=1, latch addr/rw/wdata, clear ack_err, set busy=1 the next cycle, and go to START. A start while busy=1 is ignored.
- START (3Q):
  - Q0: both lines released.
  - Q1: SDA low.
  - Q2: SCL low.
- Bit slot (4Q), used by ADDR, ADDR_ACK, DATA, DATA_ACK:
  - Q0/Q1: SCL low; SDA set at start of Q0.
  - Q2/Q3: SCL released; sda_in sampled on the last clk of Q2.
  - Bits are sent MSB first. A '1' releases SDA; a '0' pulls it low.
- ADDR: 8 bit slots sending {addr, rw}.
- ADDR_ACK: SDA released. Sampled 1 → ack_err=1, go to STOP and skip the data byte.
- DATA:
  - Write: send wdata MSB first.
  - Read: SDA released; shift in sda_in MSB first.
- DATA_ACK:
  - Write: SDA released; sampled 1 → ack_err=1.
  - Read: master sends NACK (SDA released); rdata updated from the shift register at the end of this slot.
- STOP (3Q):
  - Q0: SCL low, SDA low.
  - Q1: SCL released, SDA low.
  - Q2: SDA released.
  - Then done=1 for one cycle, busy=0, return to IDLE.
- Full transaction = 78Q (3+36+36+3). Address NACK = 42Q. done is asserted the clk after the final tick.

Optional Feature:
- Macro: I2C_STRETCH_EN.
- Defined: after releasing SCL (start of Q2), the quarter counter holds while scl_in=0. Q2 starts counting only once scl_in=1, supporting slave clock stretching. No timeout.
- Undefined: scl_in ignored; timing purely from CLK_DIV.

Test Plan:
- Write with ACK: CLK_DIV=4, addr=0x50, rw=0, wdata=0x2A, slave ACKs both → SDA bits 0xA0 then 0x2A; done pulses 312 clk after busy rises; ack_err=0.
- Address NACK: addr=0x11, slave never pulls SDA → ack_err=1, STOP directly after ADDR_ACK; done 168 clk after busy; no data bits on bus.
- Read: addr=0x50, rw=1, slave ACKs then drives 0x5C → rdata=0x5C at done; master leaves SDA released in DATA_ACK (NACK); ack_err=0.
- Start while busy: second start pulse mid-ADDR with different addr → ignored; bus shows only the first transaction; exactly one done.
- Reset mid-DATA: assert i2c_rst during bit 3 of data → same cycle scl_oe=0, sda_oe=0, busy=0; next start after release runs a clean full transaction.
- Stretch (I2C_STRETCH_EN): slave holds scl_in=0 for 20 clk in addr bit 0 → high phase delayed by 20 clk; all bits intact; total time 312+20 clk.

Source files
------------

// File: rtl/i2c_master_prog.sv
// i2c_master_prog: single-byte I2C master (START, addr+rw, ACK, data, ACK/NACK, STOP).
// Define I2C_STRETCH_EN to hold the quarter counter while a slave stretches SCL.
module i2c_master_prog #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       i2c_rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    input  logic       sda_in,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);
    typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;
    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d, rx_q, rx_d, rdata_q, rdata_d, tx_a;
    logic       busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
    logic       scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic       hold, tick, slot, slot_d;

    assign slot = state_q inside {ADDR, ADDR_ACK, DATA, DATA_ACK};
`ifdef I2C_STRETCH_EN
    assign hold = slot && ph_q == 2'd2 && !scl_in;
`else
    logic unused_scl;
    assign unused_scl = scl_in;
    assign hold = 1'b0;
`endif
    assign tick = qcnt_q == 8'd0 && !hold;

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bcnt_d    = bcnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        qcnt_d    = (state_q == IDLE || tick) ? QMAX : qcnt_q - (hold ? 8'd0 : 8'd1);
        if (state_q == IDLE) begin
            if (start) begin
                state_d   = START;
                ph_d      = 2'd0;
                rw_d      = rw;
                addr_d    = addr;
                wdata_d   = wdata;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
            end
        end else if (tick && !slot && ph_q == 2'd2) begin
            ph_d    = 2'd0;
            bcnt_d  = 3'd7;
            state_d = (state_q == START) ? ADDR : IDLE;
            busy_d  = state_q == START;
            done_d  = state_q == STOP;
        end else if (tick) begin
            ph_d = ph_q + 2'd1;
            // Sample point: last clk of Q2, while SCL is high
            if (slot && ph_q == 2'd2) begin
                if (state_q == DATA) rx_d = {rx_q[6:0], sda_in};
                if (state_q == ADDR_ACK || (state_q == DATA_ACK && !rw_q)) ack_err_d = sda_in;
            end
            if (slot && ph_q == 2'd3) begin
                case (state_q)
                    ADDR:     state_d = (bcnt_q == 3'd0) ? ADDR_ACK : ADDR;
                    ADDR_ACK: state_d = ack_err_q ? STOP : DATA;
                    DATA:     state_d = (bcnt_q == 3'd0) ? DATA_ACK : DATA;
                    default:  state_d = STOP;
                endcase
                bcnt_d = (state_q == ADDR || state_q == DATA) ? bcnt_q - 3'd1 : 3'd7;
                if (state_q == DATA_ACK && rw_q) rdata_d = rx_q;
            end
        end
    end

    // Line drives decoded from the next state so the pins come straight from flops
    assign slot_d   = state_d inside {ADDR, ADDR_ACK, DATA, DATA_ACK};
    assign tx_a     = {addr_d, rw_d};
    assign scl_oe_d = (state_d == START) ? (ph_d == 2'd2) :
                      (state_d == STOP)  ? (ph_d == 2'd0) : (slot_d && !ph_d[1]);
    assign sda_oe_d = (state_d == START) ? (ph_d != 2'd0) :
                      (state_d == STOP)  ? (ph_d != 2'd2) :
                      (state_d == ADDR)  ? !tx_a[bcnt_d] : (state_d == DATA && !rw_d && !wdata_d[bcnt_d]);

    always_ff @(posedge clk or posedge i2c_rst) begin
        if (i2c_rst) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            ph_q      <= '0;
            bcnt_q    <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            ph_q      <= ph_d;
            bcnt_q    <= bcnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_oe_q  <= scl_oe_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign scl_oe  = scl_oe_q;
    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
endmodule
